// File: rtl/vx_tcu_drl_mask_expand.sv
// Expands DRL per-lane valid masks into per-element operand masks.
// Format is latched per block of BEATS beats; output is an elastic register + skid stage.
module vx_tcu_drl_mask_expand #(
  parameter int N              = 2,
  parameter int TCK            = 2 * N,
  parameter int BEATS          = 4,
  parameter int TCU_MAX_INPUTS = 4 * TCK
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  valid_in,
  output logic                                  ready_in,
  input  logic [TCK-1:0]                        lane_mask_in,
  input  logic [3:0]                            fmt_s,
  output logic                                  valid_out,
  input  logic                                  ready_out,
  output logic [TCU_MAX_INPUTS-1:0]             vld_mask_out,
  output logic [$clog2(TCU_MAX_INPUTS+1)-1:0]   elem_cnt_out,
  output logic [$clog2(BEATS)-1:0]              beat_idx_out,
  output logic                                  last_out,
  output logic                                  fmt_err
);

  localparam int CW = $clog2(TCU_MAX_INPUTS + 1);
  localparam int BW = $clog2(BEATS);

  localparam logic [3:0] TCU_FP16_ID = 4'd1;
  localparam logic [3:0] TCU_BF16_ID = 4'd2;
  localparam logic [3:0] TCU_FP8_ID  = 4'd3;
  localparam logic [3:0] TCU_BF8_ID  = 4'd4;
  localparam logic [3:0] TCU_TF32_ID = 4'd5;
  localparam logic [3:0] TCU_I8_ID   = 4'd9;
  localparam logic [3:0] TCU_U8_ID   = 4'd10;
  localparam logic [3:0] TCU_I4_ID   = 4'd11;
  localparam logic [3:0] TCU_U4_ID   = 4'd12;

  if (TCU_MAX_INPUTS < 4 * TCK) begin : g_bad_inputs
    $error("TCU_MAX_INPUTS must be at least 4*TCK");
  end
  if (BEATS < 2 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_beats
    $error("BEATS must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [TCU_MAX_INPUTS-1:0] mask;
    logic [CW-1:0]             cnt;
    logic [BW-1:0]             idx;
    logic                      last;
  } beat_t;

  logic [BW-1:0] bcnt_reg;
  logic [3:0]    fmt_q_reg;
  logic          fmt_err_reg;
  logic          out_valid_reg;
  logic          skid_valid_reg;
  beat_t         out_reg;
  beat_t         skid_reg;
  beat_t         beat_next;

  logic          first_beat;
  logic [3:0]    fmt_eff;
  logic          is_half, is_tf32, is_byte, is_nib, fmt_known;
  logic          accept, out_ready, err_next;
  logic [4*TCK-1:0]          lane_elems;
  logic [TCU_MAX_INPUTS-1:0] mask_next;
  logic [CW-1:0]             cnt_next;

  assign first_beat = (bcnt_reg == '0);
  assign fmt_eff    = first_beat ? fmt_s : fmt_q_reg;

  always_comb begin
    is_half = 1'b0;
    is_tf32 = 1'b0;
    is_byte = 1'b0;
    is_nib  = 1'b0;
    case (fmt_eff)
      TCU_FP16_ID, TCU_BF16_ID:                     is_half = 1'b1;
      TCU_TF32_ID:                                  is_tf32 = 1'b1;
      TCU_FP8_ID, TCU_BF8_ID, TCU_I8_ID, TCU_U8_ID: is_byte = 1'b1;
      TCU_I4_ID, TCU_U4_ID:                         is_nib  = 1'b1;
      default: ;
    endcase
  end

  assign fmt_known = is_half | is_tf32 | is_byte | is_nib;

  // Each lane owns a 4-element slot; an unknown format leaves every flag low.
  genvar gi;
  for (gi = 0; gi < TCK; gi++) begin : g_lane
    localparam bit EVEN_LANE = (gi % 2) == 0;
    logic lane;
    assign lane = lane_mask_in[gi];
    assign lane_elems[4*gi +: 4] = {
      is_nib & lane,
      (is_nib | is_byte) & lane,
      is_nib & lane,
      (is_half | is_byte | is_nib | (is_tf32 & EVEN_LANE)) & lane
    };
  end

  assign mask_next = TCU_MAX_INPUTS'(lane_elems);

  always_comb begin
    cnt_next = '0;
    for (int k = 0; k < TCU_MAX_INPUTS; k++) begin
      cnt_next = cnt_next + CW'(mask_next[k]);
    end
  end

  assign beat_next.mask = mask_next;
  assign beat_next.cnt  = cnt_next;
  assign beat_next.idx  = bcnt_reg;
  assign beat_next.last = (bcnt_reg == BW'(BEATS - 1));

  assign ready_in  = !skid_valid_reg;
  assign accept    = valid_in && ready_in;
  assign out_ready = !out_valid_reg || ready_out;
  assign err_next  = fmt_err_reg |
                     (accept & (!fmt_known | (!first_beat & (fmt_s != fmt_q_reg))));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_reg       <= '0;
      fmt_q_reg      <= '0;
      fmt_err_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
      out_reg        <= '0;
      skid_reg       <= '0;
    end else begin
      if (accept) begin
        bcnt_reg <= bcnt_reg + BW'(1);
        if (first_beat) fmt_q_reg <= fmt_s;
      end
      fmt_err_reg <= err_next;
      // A full skid implies no accept this cycle, so skid and new beat never collide.
      if (out_ready) begin
        if (skid_valid_reg) begin
          out_reg        <= skid_reg;
          out_valid_reg  <= 1'b1;
          skid_valid_reg <= 1'b0;
        end else begin
          out_valid_reg <= accept;
          if (accept) out_reg <= beat_next;
        end
      end else if (accept) begin
        skid_reg       <= beat_next;
        skid_valid_reg <= 1'b1;
      end
    end
  end

  assign valid_out    = out_valid_reg;
  assign vld_mask_out = out_reg.mask;
  assign elem_cnt_out = out_reg.cnt;
  assign beat_idx_out = out_reg.idx;
  assign last_out     = out_reg.last;
  assign fmt_err      = fmt_err_reg;

endmodule

// File: tb/tb_vx_tcu_drl_mask_expand.sv
// Scoreboard bench for vx_tcu_drl_mask_expand (N=2, TCK=4, BEATS=4, 16 elements).
module tb_vx_tcu_drl_mask_expand;

  localparam logic [3:0] FP16 = 4'd1, BF16 = 4'd2, FP8 = 4'd3, BF8 = 4'd4, TF32 = 4'd5;
  localparam logic [3:0] I8 = 4'd9, U8 = 4'd10, I4 = 4'd11, U4 = 4'd12;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [3:0]  lane_mask_in = '0;
  logic [3:0]  fmt_s = '0;
  logic        valid_out;
  logic        ready_out = 1'b1;
  logic [15:0] vld_mask_out;
  logic [4:0]  elem_cnt_out;
  logic [1:0]  beat_idx_out;
  logic        last_out;
  logic        fmt_err;

  always #5 clk = ~clk;

  vx_tcu_drl_mask_expand dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .lane_mask_in (lane_mask_in),
    .fmt_s        (fmt_s),
    .valid_out    (valid_out),
    .ready_out    (ready_out),
    .vld_mask_out (vld_mask_out),
    .elem_cnt_out (elem_cnt_out),
    .beat_idx_out (beat_idx_out),
    .last_out     (last_out),
    .fmt_err      (fmt_err)
  );

  typedef struct {
    logic [15:0] mask;
    logic [4:0]  cnt;
    logic [1:0]  idx;
    logic        last;
    logic [3:0]  fmt;
    logic [3:0]  lanes_rt;
  } exp_t;

  exp_t        sb[$];
  int          tests_run = 0;
  int          fail_cnt = 0;
  int          inflight = 0;
  logic [1:0]  bcnt_m = '0;
  logic [3:0]  fmtq_m = '0;
  logic        err_m = 1'b0;
  logic        ovr = 1'b0;
  logic [15:0] ovr_mask = '0;
  logic [4:0]  ovr_cnt = '0;
  logic        prev_stall = 1'b0;
  logic [15:0] p_mask;
  logic [4:0]  p_cnt;
  logic [1:0]  p_idx;
  logic        p_last;
  logic [3:0]  known_fmts [9];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_known(input logic [3:0] f);
    case (f)
      FP16, BF16, TF32, FP8, BF8, I8, U8, I4, U4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] expand(input logic [3:0] f, input logic [3:0] l);
    logic [15:0] m;
    int lane, pos;
    logic en;
    m = '0;
    for (int e = 0; e < 16; e++) begin
      lane = e / 4;
      pos  = e % 4;
      case (f)
        FP16, BF16:       en = (pos == 0);
        TF32:             en = (pos == 0) && (lane % 2 == 0);
        FP8, BF8, I8, U8: en = (pos % 2 == 0);
        I4, U4:           en = 1'b1;
        default:          en = 1'b0;
      endcase
      m[e] = en & l[lane];
    end
    return m;
  endfunction

  function automatic logic [3:0] compress(input logic [3:0] f, input logic [15:0] m);
    logic [3:0] l;
    l = '0;
    for (int i = 0; i < 4; i++) begin
      case (f)
        FP16, BF16, TF32: l[i] = m[4*i];
        FP8, BF8, I8, U8: l[i] = m[4*i] & m[4*i+2];
        I4, U4:           l[i] = m[4*i] & m[4*i+1] & m[4*i+2] & m[4*i+3];
        default:          l[i] = 1'b0;
      endcase
    end
    return l;
  endfunction

  // One cycle: check state at the negedge, account for the handshakes, advance to the next negedge.
  task automatic tick();
    exp_t e;
    logic acc, pop;
    logic [3:0] fu;
    logic [15:0] m;
    chk("ready_in", ready_in, inflight < 2);
    chk("valid_out", valid_out, inflight > 0);
    chk("fmt_err", fmt_err, err_m);
    if (prev_stall) begin
      chk("hold_mask", vld_mask_out, p_mask);
      chk("hold_cnt", elem_cnt_out, p_cnt);
      chk("hold_idx", beat_idx_out, p_idx);
      chk("hold_last", last_out, p_last);
    end
    pop = valid_out && ready_out;
    acc = valid_in && ready_in;
    if (pop) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("[TB] out idx=%0d last=%0d mask=%h cnt=%0d err=%0d",
                 beat_idx_out, last_out, vld_mask_out, elem_cnt_out, fmt_err);
        chk("mask", vld_mask_out, e.mask);
        chk("cnt", elem_cnt_out, e.cnt);
        chk("idx", beat_idx_out, e.idx);
        chk("last", last_out, e.last);
        chk("round_trip", compress(e.fmt, vld_mask_out), e.lanes_rt);
      end
    end
    if (acc) begin
      fu = (bcnt_m == 2'd0) ? fmt_s : fmtq_m;
      if (bcnt_m == 2'd0) fmtq_m = fmt_s;
      else if (fmt_s != fmtq_m) err_m = 1'b1;
      if (!is_known(fu)) err_m = 1'b1;
      m = expand(fu, lane_mask_in);
      e.mask = ovr ? ovr_mask : m;
      e.cnt  = ovr ? ovr_cnt : 5'($countones(m));
      e.idx  = bcnt_m;
      e.last = (bcnt_m == 2'd3);
      e.fmt  = fu;
      e.lanes_rt = !is_known(fu) ? 4'b0 : (fu == TF32) ? (lane_mask_in & 4'b0101) : lane_mask_in;
      sb.push_back(e);
      bcnt_m = bcnt_m + 2'd1;
    end
    inflight = inflight + int'(acc) - int'(pop);
    prev_stall = valid_out && !ready_out;
    p_mask = vld_mask_out;
    p_cnt  = elem_cnt_out;
    p_idx  = beat_idx_out;
    p_last = last_out;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [3:0] f, input logic [3:0] l,
                      input logic [15:0] m, input logic [4:0] c);
    logic accepted;
    int n;
    valid_in = 1'b1;
    fmt_s = f;
    lane_mask_in = l;
    ovr = 1'b1;
    ovr_mask = m;
    ovr_cnt = c;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 20) begin
      accepted = ready_in;
      tick();
      n++;
    end
    chk("beat_accept", accepted, 1);
    valid_in = 1'b0;
    ovr = 1'b0;
  endtask

  task automatic drain();
    int n;
    valid_in = 1'b0;
    ready_out = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    chk("drain_empty", sb.size(), 0);
    tick();
  endtask

  task automatic model_reset();
    sb.delete();
    inflight = 0;
    bcnt_m = '0;
    fmtq_m = '0;
    err_m = 1'b0;
    prev_stall = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, cyc;
    logic [3:0] rnd_fmt;
    known_fmts = '{FP16, BF16, TF32, FP8, BF8, I8, U8, I4, U4};
    rnd_fmt = FP16;

    repeat (2) @(negedge clk);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_mask", vld_mask_out, 0);
    chk("rst_cnt", elem_cnt_out, 0);
    chk("rst_idx", beat_idx_out, 0);
    chk("rst_last", last_out, 0);
    chk("rst_fmt_err", fmt_err, 0);
    chk("rst_ready_in", ready_in, 1);
    reset = 1'b0;
    @(negedge clk);

    // Directed blocks, one format per block, back to back
    beat(I4, 4'b1010, 16'hF0F0, 5'd8);
    beat(I4, 4'b0001, 16'h000F, 5'd4);
    beat(I4, 4'b1111, 16'hFFFF, 5'd16);
    beat(I4, 4'b0000, 16'h0000, 5'd0);
    beat(I8, 4'b0111, 16'h0555, 5'd6);
    beat(I8, 4'b1000, 16'h5000, 5'd2);
    beat(I8, 4'b1111, 16'h5555, 5'd8);
    beat(I8, 4'b0001, 16'h0005, 5'd2);
    beat(FP16, 4'b1111, 16'h1111, 5'd4);
    beat(FP16, 4'b0101, 16'h0101, 5'd2);
    beat(FP16, 4'b1010, 16'h1010, 5'd2);
    beat(FP16, 4'b0000, 16'h0000, 5'd0);
    beat(TF32, 4'b1111, 16'h0101, 5'd2);
    beat(TF32, 4'b1010, 16'h0000, 5'd0);
    beat(TF32, 4'b0101, 16'h0101, 5'd2);
    beat(TF32, 4'b0011, 16'h0001, 5'd1);
    drain();

    // Continuous valid with random backpressure
    valid_in = 1'b1;
    acc_n = 0;
    cyc = 0;
    while (acc_n < 1000 && cyc < 5000) begin
      if (bcnt_m == 2'd0) rnd_fmt = known_fmts[$urandom_range(0, 8)];
      fmt_s = rnd_fmt;
      lane_mask_in = 4'($urandom);
      ready_out = 1'($urandom_range(0, 1));
      if (ready_in) acc_n++;
      tick();
      cyc++;
    end
    chk("rand_beats", acc_n, 1000);
    drain();
    chk("err_clean_before_unknown", fmt_err, 0);

    // Unknown format for a whole block
    beat(4'hF, 4'b1111, 16'h0000, 5'd0);
    beat(4'hF, 4'b0101, 16'h0000, 5'd0);
    beat(4'hF, 4'b1111, 16'h0000, 5'd0);
    beat(4'hF, 4'b0011, 16'h0000, 5'd0);
    drain();
    chk("unknown_err", fmt_err, 1);

    // Reset mid-block with a stalled output and full skid
    ready_out = 1'b0;
    beat(FP16, 4'b1111, 16'h1111, 5'd4);
    beat(FP16, 4'b0011, 16'h0011, 5'd2);
    chk("skid_full_ready", ready_in, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid_out", valid_out, 0);
    chk("arst_mask", vld_mask_out, 0);
    chk("arst_cnt", elem_cnt_out, 0);
    chk("arst_idx", beat_idx_out, 0);
    chk("arst_last", last_out, 0);
    chk("arst_fmt_err", fmt_err, 0);
    chk("arst_ready_in", ready_in, 1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    ready_out = 1'b1;
    tick();

    // Format switch inside a block: expansion keeps the latched FP16
    beat(FP16, 4'b1111, 16'h1111, 5'd4);
    beat(FP16, 4'b0011, 16'h0011, 5'd2);
    chk("err_before_switch", fmt_err, 0);
    beat(I8, 4'b1111, 16'h1111, 5'd4);
    beat(FP16, 4'b0001, 16'h0001, 5'd1);
    beat(FP16, 4'b0100, 16'h0100, 5'd1);
    drain();
    chk("switch_err", fmt_err, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/vx_tcu_drl_mask_expand.md
# VX_tcu_drl_mask_expand

Expands a per-lane valid mask from the TCU dot-product reduction lanes (DRL) back into a per-element input mask (`TCU_MAX_INPUTS` bits) for the selected operand format. It is the inverse of the DRL lane-mask compression and sits between the DRL lane datapath and the operand writeback and accumulate staging. The block is elastic, using a valid/ready handshake with a registered output and a skid buffer. It groups beats into fixed-size blocks, latching the format at the first beat of each block.

## Interface
- `N`, default 2: DRL lane pairs.
- `TCK`, default `2*N`: lanes per beat. `TCU_MAX_INPUTS >= 4*TCK` is required and checked by elaboration assert.
- `BEATS`, default 4: beats per block, power of two, ≥ 2.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `valid_in`  in  1  input beat valid.
- `ready_in`  out  1  block accepts a beat.
- `lane_mask_in`  in  TCK  per-lane valid mask.
- `fmt_s`  in  4  format ID (`VX_tcu_pkg` `TCU_*_ID`).
- `valid_out`  out  1  output beat valid.
- `ready_out`  in  1  downstream accepts.
- `vld_mask_out`  out  TCU_MAX_INPUTS  expanded element mask.
- `elem_cnt_out`  out  `$clog2(TCU_MAX_INPUTS+1)`  popcount of `vld_mask_out`.
- `beat_idx_out`  out  `$clog2(BEATS)`  beat index within the block.
- `last_out`  out  1  the beat has `beat_idx_out == BEATS-1`.
- `fmt_err`  out  1  sticky error flag; cleared only by `reset`.

## Operation
- Expansion for lane `i`. Element bits beyond `4*TCK` are always 0.
  - FP16 and BF16: element `4i` = `lane[i]`.
  - TF32: element `4i` = `lane[i]` for even `i`; odd lanes are ignored and produce 0.
  - FP8, BF8, I8 and U8: elements `4i` and `4i+2` = `lane[i]`.
  - I4 and U4: elements `4i` through `4i+3` = `lane[i]`.
  - Format IDs whose enable define is absent are unknown.
- Unknown format: `vld_mask_out` = 0, `elem_cnt_out` = 0, and `fmt_err` is set. The beat is still counted and forwarded.
- Block tracking:
  - Beat counter `bcnt` advances on every accepted input beat and wraps from `BEATS-1` to 0.
  - On the beat with `bcnt == 0`, `fmt_s` is latched into `fmt_q` and used for that beat.
  - Beats 1 to `BEATS-1` expand using `fmt_q`, not the live `fmt_s`.
  - If live `fmt_s` differs from `fmt_q` on beats 1 to `BEATS-1`, `fmt_err` is set and `fmt_q` is still used.
- Round-trip property: compressing `vld_mask_out` with the same format returns `lane_mask_in`. TF32 is the exception: its odd lanes return 0.
- Pipeline:
  - There is one output register stage plus a one-entry skid buffer.
  - `ready_in = !skid_valid`.
  - An input beat is accepted when `valid_in && ready_in`.
  - When output is valid and `!ready_out`, an accepted beat goes to the skid buffer.
  - When the output drains, the skid entry moves to the output register on the same edge.
  - Order is strictly preserved.
- Expansion and popcount are computed before registration, so outputs are purely registered.

## Timing
- Reset values (asynchronous): `valid_out` = 0, `vld_mask_out` = 0, `elem_cnt_out` = 0, `beat_idx_out` = 0, `last_out` = 0, `fmt_err` = 0, `bcnt` = 0, `fmt_q` = 0, skid buffer empty. With the skid empty, `ready_in` = 1 after reset.
- Latency: a beat accepted at edge t is visible on the outputs after edge t, i.e. 1 cycle.
- Throughput: 1 beat per cycle while `ready_out` = 1.
- Outputs are held stable while `valid_out && !ready_out`.
- Deassertion of `valid_in` has no effect on stored beats.
- Skid full: `ready_in` = 0 until the output drains. The skid entry moves to the output on the draining edge, and `ready_in` returns to 1 on the next cycle.
- Simultaneous drain and accept with the skid empty: the new beat is loaded directly into the output register.
- Reset mid-block: `bcnt` returns to 0, so the next accepted beat starts a new block and relatches the format. In-flight beats are dropped.
- `fmt_err` asserts one cycle after the offending beat is accepted.

## Test plan
- Reset, then I4, `TCK`=4, `lane_mask_in`=4'b1010 -> `vld_mask_out`[15:0]=16'hF0F0, `elem_cnt_out`=8, `beat_idx_out`=0, latency 1.
- I8, lanes 4'b0111 -> mask 16'h0555, count 6. FP16, lanes 4'b1111 -> 16'h1111, count 4.
- TF32, lanes 4'b1111 -> 16'h0101, count 2. Round-trip compression returns 4'b0101.
- 4 back-to-back FP16 beats with `fmt_s` switched to I8 on beat 2 -> all four expand as FP16, `fmt_err`=1 from beat 2 onward, `last_out`=1 on beat 3 only, and the next beat starts at index 0.
- Random `ready_out` (50%) with continuous `valid_in` over 1000 beats -> no loss or reorder. `ready_in` is low only while the skid is full, and outputs are stable under stall.
- Unknown `fmt_s` (e.g. 4'hF) on beat 0 -> mask 0, count 0, `fmt_err`=1. Asynchronous reset asserted mid-block -> all outputs return to their reset values immediately.
